// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc : WIDTH-bit ALU with a registered result, status flags and a
//          start/done handshake. Single-cycle ADD/SUB/AND/OR/XOR/PASSA and
//          a multi-cycle shift-add unsigned multiply (one bit per clock).
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   start      request; sampled only while busy = 0
//   op[2:0]    000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL,
//              110 PASSA, 111 reserved (result 0)
//   a, b       operands (unsigned; signed only for the ovf interpretation)
//   busy       high while a MUL is iterating
//   done       one-cycle pulse: result/flags were updated this cycle
//   result     registered result (MUL: low half of the product)
//   result_hi  MUL: high half of the product; 0 for every other op
//   cout       ADD/SUB carry out (SUB: 1 = no borrow); MUL: OR of result_hi
//   zero       result == 0
//   neg        result[WIDTH-1]
//   ovf        ADD/SUB signed overflow; 0 otherwise
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter  int WIDTH = 16,
    localparam int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_PASSA = 3'b110;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t state;

    // Multiply datapath: multiplicand, and the product register {hi, lo}.
    // lo starts as the multiplier and is consumed one bit per iteration
    // while the product bits shift in from hi.
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [CNTW-1:0]  cnt;

    // ------------------------------------------------------------------
    // Single-cycle ALU result, evaluated straight from the inputs so it
    // can be registered on the accepting edge.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves a signal unassigned (which would infer a latch).
    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        b_eff    = (op == OP_SUB) ? ~b : b;
        // SUB is a + ~b + 1; the +1 enters as the carry-in.
        sum_ext  = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(op == OP_SUB);
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res  = sum_ext[WIDTH-1:0];
                alu_cout = sum_ext[WIDTH];
                // Same-signed addends whose sum flips sign overflowed.
                alu_ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   alu_res = a & b;
            OP_OR:    alu_res = a | b;
            OP_XOR:   alu_res = a ^ b;
            OP_PASSA: alu_res = a;
            default:  alu_res = '0;   // reserved op (and MUL, unused here)
        endcase
    end

    // ------------------------------------------------------------------
    // One shift-add iteration: conditionally add the multiplicand into hi
    // (keeping the carry), then shift {carry, hi, lo} right by one.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    always_comb begin
        mul_sum = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : '0);
        hi_next = mul_sum[WIDTH:1];
        lo_next = {mul_sum[0], mul_lo[WIDTH-1:1]};
    end

    wire last_iter = (cnt == CNTW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Control FSM and all registered outputs.
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here; it is only a data input on the
        // rising edge, so an aborted MUL simply never reaches its done edge.
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            mcand     <= '0;
            mul_hi    <= '0;
            mul_lo    <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;   // pulse unless re-asserted below
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
                            mcand  <= a;
                            mul_hi <= '0;
                            mul_lo <= b;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= MUL;
                        end else begin
                            result    <= alu_res;
                            result_hi <= '0;
                            cout      <= alu_cout;
                            ovf       <= alu_ovf;
                            zero      <= (alu_res == '0);
                            neg       <= alu_res[WIDTH-1];
                            done      <= 1'b1;
                        end
                    end
                end

                MUL: begin
                    mul_hi <= hi_next;
                    mul_lo <= lo_next;
                    cnt    <= cnt + CNTW'(1);
                    // The final iteration's outcome is registered directly
                    // from the next-value terms so done lands on this edge.
                    if (last_iter) begin
                        result    <= lo_next;
                        result_hi <= hi_next;
                        cout      <= |hi_next;
                        ovf       <= 1'b0;
                        zero      <= (lo_next == '0);
                        neg       <= lo_next[WIDTH-1];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised successor to the 16-bit ripple ALU: WIDTH-bit ALU with registered result, status flags and a start/done handshake. Adds XOR, pass-through, and a multi-cycle shift-add unsigned multiply. Sits between the register file and the writeback register. The controller issues `start` and waits for `done` before consuming `result`.

Parameters:
WIDTH, 16, operand/result width in bits (>=2)
CNTW, $clog2(WIDTH)+1, multiply iteration counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 PASSA, 111 reserved
a  input  WIDTH  operand A
b  input  WIDTH  operand B
busy  output  1  high while a MUL is iterating
done  output  1  one-cycle pulse: result/flags updated this cycle
result  output  WIDTH  registered result (MUL: low half of product)
result_hi  output  WIDTH  MUL: high half of product; 0 for all other ops
cout  output  1  ADD/SUB carry out; MUL: OR of result_hi; else 0
zero  output  1  result == 0
neg  output  1  result[WIDTH-1]
ovf  output  1  ADD/SUB signed overflow; else 0

Behaviour:
- Reset: clk and reset are the only clock and reset; reset is synchronous and active-high. On any edge with reset=1, all outputs go to 0 and the FSM enters IDLE. This includes reset mid-MUL: the operation is aborted and no done pulse is produced.
- FSM states: IDLE, MUL.
- IDLE, start=1, op != MUL: operands and op are sampled at edge T. At edge T, result/result_hi/flags are registered and done=1 for the following cycle. busy stays 0. Latency is 1 cycle.
- IDLE, start=1, op=MUL: at edge T, latch multiplicand=a and the product register {hi=0, lo=b}, clear the counter, go to MUL, busy=1.
- MUL: each edge performs one iteration: if lo[0]=1, hi += multiplicand (WIDTH+1-bit sum); then shift {carry,hi,lo} right by 1; counter++.
  - Exit: the edge on which counter reaches WIDTH-1 completes the final iteration, registers result=lo and result_hi=hi, updates flags, sets done=1, and returns to IDLE with busy=0.
  - busy is high for exactly WIDTH cycles following the acceptance edge. done is asserted in the cycle after busy falls, i.e. at T+WIDTH.
- start while busy=1 is ignored; no queueing.
- start during a done cycle is accepted, so back-to-back operation is legal.
- SUB: result = a + ~b + 1. cout=1 means no borrow.
- ovf, ADD: a and b have the same sign and result's sign differs.
- ovf, SUB: a and ~b have the same sign and result's sign differs.
- AND/OR/XOR/PASSA: cout=0, ovf=0, result_hi=0.
- Reserved op 111: result=0, zero=1, other flags 0, done still pulsed.
- result, result_hi and flags hold their values between done pulses. done is never high for two consecutive cycles unless back-to-back single-cycle ops are issued.
- All arithmetic is modulo 2^WIDTH (MUL: 2^(2*WIDTH)). Operands are unsigned except for the ovf interpretation.

Test Plan:
- Reset mid-MUL: start MUL a=16'h00FF b=16'h0101; assert reset at cycle 5 -> busy=0, all outputs 0, no done. Next ADD 1+1 -> result=2, done one cycle later.
- ADD, WIDTH=16: a=16'hFFFF b=16'h0001 -> result=0, cout=1, zero=1, ovf=0. Then a=16'h7FFF b=16'h0001 -> result=16'h8000, ovf=1, neg=1, cout=0.
- SUB: a=5 b=7 -> result=16'hFFFE, cout=0, neg=1. Then a=7 b=5 -> result=2, cout=1.
- MUL timing: a=16'h1234 b=16'h0100 -> busy high exactly 16 cycles, done at T+16, result=16'h3400, result_hi=16'h0012, cout=1. A start pulsed mid-busy is ignored.
- Logic and back-to-back: XOR a=16'hAAAA b=16'hFFFF -> 16'h5555; next cycle AND with same operands -> 16'hAAAA. Two consecutive done pulses; op 111 -> result=0, zero=1.
- WIDTH=8 instance: MUL 8'hFF*8'hFF -> result=8'h01, result_hi=8'hFE, busy for 8 cycles.
